hwpe_stream_realign_ctrl_gen: RTL and testbench

HWPE_STREAM_REALIGN_CTRL_GEN -- requirements
Module: hwpe_stream_realign_ctrl_gen

---
 rtl/hwpe_stream_realign_ctrl_gen_if.sv | 28 ++
 rtl/hwpe_stream_realign_ctrl_gen.sv | 181 ++++++++++++++++++
 tb/tb_hwpe_stream_realign_ctrl_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_realign_ctrl_gen_if.sv
// Request-side bus of the realign control generator: package with the realigner control word, plus the request interface.
package hwpe_stream_realign_ctrl_gen_pkg;
  typedef struct packed {
    logic enable;
    logic realign;
    logic first;
    logic last;
    logic last_packet;
  } ctrl_realign_t;
endpackage

interface hwpe_stream_realign_ctrl_gen_if
  import hwpe_stream_realign_ctrl_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [ADDR_WIDTH-1:0] req_addr_o;
  logic [NB-1:0]         req_strb_o;
  ctrl_realign_t         ctrl_o;

  modport master (output req_valid_o, req_addr_o, req_strb_o, ctrl_o, input req_ready_i);
  modport slave  (input req_valid_o, req_addr_o, req_strb_o, ctrl_o, output req_ready_i);
endinterface

// File: rtl/hwpe_stream_realign_ctrl_gen.sv
// Splits a byte-addressed transfer into word requests with byte strobes and realigner control.
// Optional stall counter enabled by macro HWPE_STREAM_REALIGN_CTRL_PERF_EN.
module hwpe_stream_realign_ctrl_gen
  import hwpe_stream_realign_ctrl_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            perf_stall_o,
  hwpe_stream_realign_ctrl_gen_if.master req
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned LOG_NB = $clog2(NB);
  localparam int unsigned SUM_W  = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e              r_state, w_state_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [NB-1:0]       r_strb, w_strb_nxt;
  ctrl_realign_t       r_ctrl, w_ctrl_nxt;
  logic [SUM_W-1:0]    r_left, w_left_nxt;
  logic [LOG_NB-1:0]   r_rot, w_rot_nxt;
  logic [LOG_NB-1:0]   r_end, w_end_nxt;

  logic [LOG_NB-1:0]   w_rot;
  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W-1:0]    w_nwords;
  logic [LOG_NB-1:0]   w_end;

  // Clear bytes below rot on the first word and bytes at/above e on the last one.
  function automatic logic [NB-1:0] strb_mask(input logic first, input logic last,
                                               input logic [LOG_NB-1:0] rot,
                                               input logic [LOG_NB-1:0] e);
    logic [NB-1:0] ones;
    logic [NB-1:0] m;
    ones = '1;
    m    = ones;
    if (first) m = ones << rot;
    if (last && (e != '0)) m = m & ~(ones << e);
    return m;
  endfunction

  assign w_rot    = addr_i[LOG_NB-1:0];
  assign w_sum    = SUM_W'(len_i) + SUM_W'(w_rot);
  assign w_nwords = (w_sum + SUM_W'(NB - 1)) >> LOG_NB;
  assign w_end    = w_sum[LOG_NB-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_strb  <= '0;
      r_ctrl  <= '0;
      r_left  <= '0;
      r_rot   <= '0;
      r_end   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_addr  <= w_addr_nxt;
      r_strb  <= w_strb_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_left  <= w_left_nxt;
      r_rot   <= w_rot_nxt;
      r_end   <= w_end_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_addr_nxt  = r_addr;
    w_strb_nxt  = r_strb;
    w_ctrl_nxt  = r_ctrl;
    w_left_nxt  = r_left;
    w_rot_nxt   = r_rot;
    w_end_nxt   = r_end;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_busy_nxt         = 1'b1;
          w_rot_nxt          = w_rot;
          w_end_nxt          = w_end;
          w_ctrl_nxt         = '0;
          w_ctrl_nxt.enable  = 1'b1;
          w_ctrl_nxt.realign = (w_rot != '0);
          if (len_i == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt            = ISSUE;
            w_valid_nxt            = 1'b1;
            w_addr_nxt             = addr_i & ~ADDR_WIDTH'(NB - 1);
            w_left_nxt             = w_nwords - SUM_W'(1);
            w_strb_nxt             = strb_mask(1'b1, w_nwords == SUM_W'(1), w_rot, w_end);
            w_ctrl_nxt.first       = 1'b1;
            w_ctrl_nxt.last        = (w_nwords == SUM_W'(1));
            w_ctrl_nxt.last_packet = (w_nwords == SUM_W'(1));
          end
        end
      end
      ISSUE: begin
        if (req.req_ready_i) begin
          w_ctrl_nxt.first = 1'b0;
          if (r_left == '0) begin
            w_state_nxt            = DONE;
            w_valid_nxt            = 1'b0;
            w_done_nxt             = 1'b1;
            w_strb_nxt             = '0;
            w_ctrl_nxt.last        = 1'b0;
            w_ctrl_nxt.last_packet = 1'b0;
          end else begin
            w_addr_nxt             = r_addr + ADDR_WIDTH'(NB);
            w_left_nxt             = r_left - SUM_W'(1);
            w_strb_nxt             = strb_mask(1'b0, r_left == SUM_W'(1), r_rot, r_end);
            w_ctrl_nxt.last        = (r_left == SUM_W'(1));
            w_ctrl_nxt.last_packet = (r_left == SUM_W'(1));
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_addr_nxt  = '0;
        w_strb_nxt  = '0;
        w_ctrl_nxt  = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req.req_valid_o = r_valid;
  assign req.req_addr_o  = r_addr;
  assign req.req_strb_o  = r_strb;
  assign req.ctrl_o      = r_ctrl;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

`ifdef HWPE_STREAM_REALIGN_CTRL_PERF_EN
  logic [31:0] r_stall;

  // Saturating backpressure counter, restarted on every accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && start_i) begin
      r_stall <= '0;
    end else if (r_valid && !req.req_ready_i && (r_stall != '1)) begin
      r_stall <= r_stall + 32'(1);
    end
  end

  assign perf_stall_o = r_stall;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_realign_ctrl_gen.sv
// Directed + randomized bench for hwpe_stream_realign_ctrl_gen against a byte-level transfer model.
module tb_hwpe_stream_realign_ctrl_gen;
  import hwpe_stream_realign_ctrl_gen_pkg::*;

  localparam int NB = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] perf_stall_o;

  int n_cmp = 0;
  int n_err = 0;

  hwpe_stream_realign_ctrl_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) req_if ();

  hwpe_stream_realign_ctrl_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .addr_i       (addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .perf_stall_o (perf_stall_o),
    .req          (req_if)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(req_if.req_valid_o), 64'(0));
    chk({tag, "_busy"},  64'(busy_o), 64'(0));
    chk({tag, "_done"},  64'(done_o), 64'(0));
  endtask

  // One transfer: model expected words from individual bytes, then walk the handshakes.
  task automatic run_xfer(input logic [31:0] a, input int l, input int stall_word,
                          input int stall_cycles, input bit rnd, input bit noise);
    logic [NB-1:0] es [0:63];
    int rot, nw, w, held, budget, exp_stall, off;
    logic [31:0] base;
    logic rdy;
    ctrl_realign_t ec;
    rot  = int'(a % NB);
    base = a - 32'(rot);
    nw   = (rot + l + NB - 1) / NB;
    for (int i = 0; i < 64; i++) es[i] = '0;
    for (int b = 0; b < l; b++) begin
      off = rot + b;
      es[off / NB][off % NB] = 1'b1;
    end
    start_i = 1'b1; addr_i = a; len_i = 16'(l);
    @(negedge clk_i);
    start_i = 1'b0;
    exp_stall = 0;
    if (l == 0) begin
      chk("len0_done",  64'(done_o), 64'(1));
      chk("len0_valid", 64'(req_if.req_valid_o), 64'(0));
      chk("len0_busy",  64'(busy_o), 64'(1));
      @(negedge clk_i);
      chk_idle("len0_after");
      return;
    end
    w = 0; held = 0; budget = 0;
    while (w < nw && budget < 500) begin
      ec.enable = 1'b1; ec.realign = (rot != 0); ec.first = (w == 0);
      ec.last = (w == nw - 1); ec.last_packet = (w == nw - 1);
      chk("valid", 64'(req_if.req_valid_o), 64'(1));
      chk("addr",  64'(req_if.req_addr_o), 64'(base + 32'(w * NB)));
      chk("strb",  64'(req_if.req_strb_o), 64'(es[w]));
      chk("ctrl",  64'(req_if.ctrl_o), 64'(ec));
      chk("busy",  64'(busy_o), 64'(1));
      chk("done_early", 64'(done_o), 64'(0));
      if (w == stall_word && held < stall_cycles) begin
        rdy = 1'b0;
        held++;
      end else begin
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (noise) begin
        start_i = 1'($urandom_range(0, 1));
        addr_i  = $urandom;
        len_i   = 16'($urandom);
      end
      req_if.req_ready_i = rdy;
      if (!rdy) exp_stall++;
      @(negedge clk_i);
      if (rdy) w++;
      budget++;
    end
    chk("words_issued", 64'(w), 64'(nw));
    start_i = 1'b0; req_if.req_ready_i = 1'b0;
    chk("done_pulse", 64'(done_o), 64'(1));
    chk("done_valid", 64'(req_if.req_valid_o), 64'(0));
    chk("done_busy",  64'(busy_o), 64'(1));
`ifdef HWPE_STREAM_REALIGN_CTRL_PERF_EN
    chk("perf_stall", 64'(perf_stall_o), 64'(exp_stall));
`else
    chk("perf_stall", 64'(perf_stall_o), 64'(0));
`endif
    @(negedge clk_i);
    chk_idle("after_done");
  endtask

  initial begin
    req_if.req_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 64'(req_if.req_valid_o), 64'(0));
    chk("rst_busy",  64'(busy_o), 64'(0));
    chk("rst_done",  64'(done_o), 64'(0));
    chk("rst_addr",  64'(req_if.req_addr_o), 64'(0));
    chk("rst_strb",  64'(req_if.req_strb_o), 64'(0));
    chk("rst_ctrl",  64'(req_if.ctrl_o), 64'(0));
    chk("rst_perf",  64'(perf_stall_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);

    run_xfer(32'h100, 8, -1, 0, 1'b0, 1'b0);
    run_xfer(32'h101, 8, -1, 0, 1'b0, 1'b0);
    run_xfer(32'h102, 1, -1, 0, 1'b0, 1'b0);
    run_xfer(32'h100, 8, 1, 3, 1'b0, 1'b0);
    run_xfer(32'h103, 0, -1, 0, 1'b0, 1'b0);
    run_xfer(32'h107, 5, -1, 0, 1'b0, 1'b0);

    // Clear in the middle of word 1 of an unaligned transfer.
    start_i = 1'b1; addr_i = 32'h101; len_i = 16'd8;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("clr_w0_addr", 64'(req_if.req_addr_o), 64'(32'h100));
    req_if.req_ready_i = 1'b1;
    @(negedge clk_i);
    chk("clr_w1_addr", 64'(req_if.req_addr_o), 64'(32'h104));
    req_if.req_ready_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk_idle("clr");
    chk("clr_addr", 64'(req_if.req_addr_o), 64'(0));
    chk("clr_strb", 64'(req_if.req_strb_o), 64'(0));
    chk("clr_ctrl", 64'(req_if.ctrl_o), 64'(0));
    chk("clr_perf", 64'(perf_stall_o), 64'(0));
    @(negedge clk_i);
    chk_idle("clr_next");
    run_xfer(32'h101, 8, -1, 0, 1'b0, 1'b0);

    // Clear must win over a simultaneous start.
    clear_i = 1'b1; start_i = 1'b1; addr_i = 32'h100; len_i = 16'd4;
    @(negedge clk_i);
    clear_i = 1'b0; start_i = 1'b0;
    chk_idle("clr_start");
    @(negedge clk_i);
    chk_idle("clr_start_next");

    for (int k = 0; k < 25; k++) begin
      run_xfer(32'h200 + 32'($urandom_range(0, 255)), int'($urandom_range(0, 23)), -1, 0, 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
